// File: rtl/mips_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// mips_hazard_ctrl
//
// Hazard and operand-forwarding controller for the pipelined MIPS core.
// It tracks every in-flight register writer in the DEPTH stages after ID.
// From that record it produces:
//   - the forwarding selects for both ID source operands;
//   - load-use stalls;
//   - squashes for branches, jumps and jr resolved in EX;
//   - a global freeze while data memory is busy.
//
// Parameters
//   DEPTH     post-ID stages that can hold a writer (1=EX, 2=MEM, 3=WB), 2..6
//   RW        register address width
//   LOAD_LAT  a load result can be forwarded only from a stage index above
//             LOAD_LAT; legal range 1..DEPTH-1
//
// Ports
//   clk           core clock
//   reset         asynchronous, active-low reset; forces every output to 0
//   id_valid      ID holds a real instruction
//   id_rs, id_rt  source register numbers of the ID instruction
//   id_uses_rs/rt the operand is actually read
//   id_regwrite   the ID instruction writes a register
//   id_dest       resolved destination register (rd, rt or 31)
//   id_memread    the ID instruction is a load
//   ex_redirect   EX resolved a taken branch, jump or jr
//   mem_busy      data memory is not ready, so the whole pipe must hold
//   stall_if_id   hold the PC and the IF/ID register
//   flush_if_id   load a NOP into IF/ID
//   bubble_ex     load a NOP into ID/EX
//   freeze        hold every pipeline register
//   fwd_a, fwd_b  0 = register file, k = value taken from post-ID stage k
//   perf_stalls   saturating count of stall cycles that are not freezes
//   perf_flushes  saturating count of IF/ID flush cycles
//
// Build option
//   MIPS_HAZARD_PERF_EN  when defined, builds the two 32-bit performance
//                        counters. When undefined, perf_* are tied to 0
//                        and no counter flops exist.
//
// Pipe contract
//   The controller and the pipe do not exchange a valid/ready handshake. The
//   outputs are level controls that the pipe obeys in the same cycle:
//   - freeze overrides every other control.
//   - stall_if_id together with bubble_ex makes ID retry next cycle while a
//     NOP enters EX.
//   - flush_if_id together with bubble_ex squashes both IF/ID and ID/EX.
//   The scoreboard shifts on exactly the edges where the pipe advances, so it
//   stays aligned with the real pipeline registers.
//
// Debug visibility
//   This block has no FSM. Its only state is the scoreboard, which is held in
//   the plainly named sb_v, sb_dest and sb_ld vectors.
// -----------------------------------------------------------------------------
module mips_hazard_ctrl #(
   parameter  int DEPTH    = 3,
   parameter  int RW       = 5,
   parameter  int LOAD_LAT = 1,
   localparam int SW       = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          id_valid,
   input  logic [RW-1:0] id_rs,
   input  logic [RW-1:0] id_rt,
   input  logic          id_uses_rs,
   input  logic          id_uses_rt,
   input  logic          id_regwrite,
   input  logic [RW-1:0] id_dest,
   input  logic          id_memread,
   input  logic          ex_redirect,
   input  logic          mem_busy,
   output logic          stall_if_id,
   output logic          flush_if_id,
   output logic          bubble_ex,
   output logic          freeze,
   output logic [SW-1:0] fwd_a,
   output logic [SW-1:0] fwd_b,
   output logic [31:0]   perf_stalls,
   output logic [31:0]   perf_flushes
);

   // Stage indices are 1-based, so the load latency is held at select width.
   localparam logic [SW-1:0] LOAD_LAT_SEL = SW'(LOAD_LAT);

   // Result of searching the scoreboard for one source operand.
   typedef struct packed {
      logic          hit;    // some valid entry writes this source
      logic          ld;     // the youngest such writer is a load
      logic [SW-1:0] stage;  // 1-based stage of that writer, 0 when no hit
   } match_t;

   // ---------------------------------------------------------------------
   // Scoreboard: bit/row k describes the writer currently in stage k+1.
   // ---------------------------------------------------------------------
   logic [DEPTH-1:0]         sb_v;
   logic [DEPTH-1:0]         sb_ld;
   logic [DEPTH-1:0][RW-1:0] sb_dest;

   // Find the youngest writer of src.
   // The walk goes from the oldest stage to the youngest, so a younger match
   // overwrites an older one. Register 0 and unused operands never match.
   function automatic match_t lookup(
      input logic [RW-1:0]            src,
      input logic                     used,
      input logic [DEPTH-1:0]         v,
      input logic [DEPTH-1:0]         ld,
      input logic [DEPTH-1:0][RW-1:0] dest
   );
      match_t m;
      m = '0;
      for (int k = DEPTH - 1; k >= 0; k--) begin
         if (v[k] && (dest[k] == src) && (src != '0) && used) begin
            m.hit   = 1'b1;
            m.ld    = ld[k];
            m.stage = SW'(k + 1);
         end
      end
      return m;
   endfunction

   match_t m_a;
   match_t m_b;
   logic   lu_a;
   logic   lu_b;
   logic   load_use;

   always_comb begin
      m_a = lookup(id_rs, id_uses_rs, sb_v, sb_ld, sb_dest);
      m_b = lookup(id_rt, id_uses_rt, sb_v, sb_ld, sb_dest);
      // A load too young to forward blocks its operand. An older writer of
      // the same register is stale, so it must not be forwarded instead.
      lu_a     = m_a.hit && m_a.ld && (m_a.stage <= LOAD_LAT_SEL);
      lu_b     = m_b.hit && m_b.ld && (m_b.stage <= LOAD_LAT_SEL);
      load_use = lu_a || lu_b;
   end

   // ---------------------------------------------------------------------
   // Pipe controls, decided in priority order. They are also gated by reset,
   // so the pipe sees quiet controls for the whole reset period.
   // ---------------------------------------------------------------------
   always_comb begin
      stall_if_id = 1'b0;
      flush_if_id = 1'b0;
      bubble_ex   = 1'b0;
      freeze      = 1'b0;
      fwd_a       = '0;
      fwd_b       = '0;
      if (reset) begin
         fwd_a = lu_a ? '0 : m_a.stage;
         fwd_b = lu_b ? '0 : m_b.stage;
         if (mem_busy) begin
            // The whole pipe holds. Forward selects stay valid because the
            // scoreboard holds as well.
            freeze      = 1'b1;
            stall_if_id = 1'b1;
         end else if (ex_redirect) begin
            // The ID instruction is on the wrong path. Squashing it makes
            // any load-use stall on its behalf pointless.
            flush_if_id = 1'b1;
            bubble_ex   = 1'b1;
         end else if (load_use) begin
            stall_if_id = 1'b1;
            bubble_ex   = 1'b1;
         end
      end
   end

   // ---------------------------------------------------------------------
   // Scoreboard shift. The new entry 0 is what enters ID/EX on this edge.
   // A bubble or a write to r0 records no writer.
   // ---------------------------------------------------------------------
   logic new_v;
   logic new_ld;

   always_comb begin
      new_v  = !bubble_ex && id_valid && id_regwrite && (id_dest != '0);
      new_ld = !bubble_ex && id_memread;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sb_v    <= '0;
         sb_ld   <= '0;
         sb_dest <= '0;
      end else if (!freeze) begin
         sb_v    <= {sb_v[DEPTH-2:0], new_v};
         sb_ld   <= {sb_ld[DEPTH-2:0], new_ld};
         sb_dest <= {sb_dest[DEPTH-2:0], id_dest};
      end
   end

   // ---------------------------------------------------------------------
   // Performance counters
   // ---------------------------------------------------------------------
`ifdef MIPS_HAZARD_PERF_EN
   logic [31:0] stall_cnt;
   logic [31:0] flush_cnt;

   // Freeze cycles are memory waits, not hazards, so they are not counted
   // as stalls. Both counters saturate.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         if (stall_if_id && !freeze && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 32'd1;
         end
         if (flush_if_id && (flush_cnt != '1)) begin
            flush_cnt <= flush_cnt + 32'd1;
         end
      end
   end

   assign perf_stalls  = stall_cnt;
   assign perf_flushes = flush_cnt;
`else
   assign perf_stalls  = '0;
   assign perf_flushes = '0;
`endif

endmodule

// File: tb/tb_mips_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mips_hazard_ctrl
//
// Directed bench for mips_hazard_ctrl with DEPTH=3, RW=5 and LOAD_LAT=1.
//
// Flow of each cycle:
//   - Instruction fields are driven 1 time unit after the rising edge.
//   - The expected control word is pushed to exp_q at the same time.
//   - On the falling edge the word is popped and compared with the outputs.
//
// Expected performance counts are accumulated from the expected controls.
// -----------------------------------------------------------------------------
module tb_mips_hazard_ctrl;

   localparam int DEPTH = 3;
   localparam int RW    = 5;
   localparam int SW    = $clog2(DEPTH + 1);

`ifdef MIPS_HAZARD_PERF_EN
   localparam bit PERF_EN = 1'b1;
`else
   localparam bit PERF_EN = 1'b0;
`endif

   // ------------------------------------------------------------ clock/reset
   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   // ------------------------------------------------------------ DUT
   logic          id_valid, id_uses_rs, id_uses_rt, id_regwrite, id_memread;
   logic [RW-1:0] id_rs, id_rt, id_dest;
   logic          ex_redirect, mem_busy;
   logic          stall_if_id, flush_if_id, bubble_ex, freeze;
   logic [SW-1:0] fwd_a, fwd_b;
   logic [31:0]   perf_stalls, perf_flushes;

   mips_hazard_ctrl #(.DEPTH(DEPTH), .RW(RW), .LOAD_LAT(1)) dut (
      .clk          (clk),
      .reset        (reset),
      .id_valid     (id_valid),
      .id_rs        (id_rs),
      .id_rt        (id_rt),
      .id_uses_rs   (id_uses_rs),
      .id_uses_rt   (id_uses_rt),
      .id_regwrite  (id_regwrite),
      .id_dest      (id_dest),
      .id_memread   (id_memread),
      .ex_redirect  (ex_redirect),
      .mem_busy     (mem_busy),
      .stall_if_id  (stall_if_id),
      .flush_if_id  (flush_if_id),
      .bubble_ex    (bubble_ex),
      .freeze       (freeze),
      .fwd_a        (fwd_a),
      .fwd_b        (fwd_b),
      .perf_stalls  (perf_stalls),
      .perf_flushes (perf_flushes)
   );

   // ------------------------------------------------------------ scoreboard
   // Each entry is {stall, flush, bubble, freeze, fwd_a[1:0], fwd_b[1:0]}.
   logic [7:0] exp_q[$];
   int n_checks = 0;
   int n_errors = 0;
   int exp_ps   = 0;
   int exp_pf   = 0;

   task automatic check_eq(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // ------------------------------------------------------------ drivers
   task automatic set_id(input logic v, input logic [RW-1:0] rs,
                         input logic [RW-1:0] rt, input logic urs,
                         input logic urt, input logic rw,
                         input logic [RW-1:0] dest, input logic mr);
      id_valid    = v;
      id_rs       = rs;
      id_rt       = rt;
      id_uses_rs  = urs;
      id_uses_rt  = urt;
      id_regwrite = rw;
      id_dest     = dest;
      id_memread  = mr;
   endtask

   task automatic alu(input logic [RW-1:0] rd, input logic [RW-1:0] rs,
                      input logic [RW-1:0] rt);
      set_id(1'b1, rs, rt, 1'b1, 1'b1, 1'b1, rd, 1'b0);
   endtask

   task automatic lw(input logic [RW-1:0] rt, input logic [RW-1:0] base);
      set_id(1'b1, base, rt, 1'b1, 1'b0, 1'b1, rt, 1'b1);
   endtask

   task automatic nop();
      set_id(1'b1, '0, '0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
   endtask

   task automatic expect_out(input logic st, input logic fl, input logic bu,
                             input logic fz, input logic [1:0] fa,
                             input logic [1:0] fb);
      exp_q.push_back({st, fl, bu, fz, fa, fb});
   endtask

   // Compare the outputs now against the oldest expectation. The expected
   // counters then advance for the next rising edge.
   task automatic check_now(input string tag);
      logic [7:0] e;
      e = exp_q.pop_front();
      check_eq({tag, ".stall"},  stall_if_id, e[7]);
      check_eq({tag, ".flush"},  flush_if_id, e[6]);
      check_eq({tag, ".bubble"}, bubble_ex,   e[5]);
      check_eq({tag, ".freeze"}, freeze,      e[4]);
      check_eq({tag, ".fwd_a"},  fwd_a,       e[3:2]);
      check_eq({tag, ".fwd_b"},  fwd_b,       e[1:0]);
      check_eq({tag, ".pstall"}, perf_stalls,  PERF_EN ? exp_ps : 0);
      check_eq({tag, ".pflush"}, perf_flushes, PERF_EN ? exp_pf : 0);
      if (e[7] && !e[4]) exp_ps++;
      if (e[6]) exp_pf++;
   endtask

   task automatic compare(input string tag);
      @(negedge clk);
      check_now(tag);
   endtask

   task automatic cycle(input string tag);
      compare(tag);
      @(posedge clk);
      #1;
   endtask

   // ------------------------------------------------------------ stimulus
   initial begin
      reset       = 1'b0;
      ex_redirect = 1'b1;
      mem_busy    = 1'b1;
      lw(5'd4, 5'd1);
      repeat (2) @(posedge clk);
      #1;
      // Reset dominates even with memory-wait and redirect raised.
      expect_out(0, 0, 0, 0, 0, 0); cycle("rst");
      reset       = 1'b1;
      ex_redirect = 1'b0;
      mem_busy    = 1'b0;

      // Forwarding distance 1, 2 and 3, and aging out beyond WB.
      alu(5'd3, 5'd1, 5'd2);  expect_out(0, 0, 0, 0, 0, 0); cycle("a1");
      alu(5'd5, 5'd3, 5'd4);  expect_out(0, 0, 0, 0, 1, 0); cycle("a2");
      nop();                  expect_out(0, 0, 0, 0, 0, 0); cycle("a3");
      alu(5'd8, 5'd3, 5'd5);  expect_out(0, 0, 0, 0, 3, 2); cycle("a4");
      alu(5'd9, 5'd5, 5'd3);  expect_out(0, 0, 0, 0, 3, 0); cycle("a5");
      for (int i = 0; i < 3; i++) begin
         nop(); expect_out(0, 0, 0, 0, 0, 0); cycle("a_nop");
      end

      // Youngest writer wins, unused operand masked, id_valid=0 inserts none.
      alu(5'd7, 5'd1, 5'd2);  expect_out(0, 0, 0, 0, 0, 0); cycle("b1");
      alu(5'd7, 5'd7, 5'd0);  expect_out(0, 0, 0, 0, 1, 0); cycle("b2");
      set_id(1'b1, 5'd7, 5'd7, 1'b1, 1'b0, 1'b1, 5'd10, 1'b0);
      expect_out(0, 0, 0, 0, 1, 0); cycle("b3");
      set_id(1'b0, 5'd10, 5'd7, 1'b1, 1'b1, 1'b1, 5'd11, 1'b0);
      expect_out(0, 0, 0, 0, 1, 2); cycle("b4");
      alu(5'd12, 5'd11, 5'd10); expect_out(0, 0, 0, 0, 0, 2); cycle("b5");
      for (int i = 0; i < 3; i++) begin
         nop(); expect_out(0, 0, 0, 0, 0, 0); cycle("b_nop");
      end

      // A write to r0 never creates a hazard.
      set_id(1'b1, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 5'd0, 1'b0);
      expect_out(0, 0, 0, 0, 0, 0); cycle("c1");
      alu(5'd7, 5'd0, 5'd0);  expect_out(0, 0, 0, 0, 0, 0); cycle("c2");
      for (int i = 0; i < 3; i++) begin
         nop(); expect_out(0, 0, 0, 0, 0, 0); cycle("c_nop");
      end

      // Load-use: one stall, then forward from MEM.
      lw(5'd4, 5'd1);         expect_out(0, 0, 0, 0, 0, 0); cycle("d1");
      alu(5'd6, 5'd4, 5'd4);  expect_out(1, 0, 1, 0, 0, 0); cycle("d2");
      alu(5'd6, 5'd4, 5'd4);  expect_out(0, 0, 0, 0, 2, 2); cycle("d3");
      for (int i = 0; i < 3; i++) begin
         nop(); expect_out(0, 0, 0, 0, 0, 0); cycle("d_nop");
      end

      // Redirect overrides load-use; the squashed add must not be recorded.
      lw(5'd4, 5'd1);         expect_out(0, 0, 0, 0, 0, 0); cycle("e1");
      alu(5'd6, 5'd4, 5'd4);
      ex_redirect = 1'b1;     expect_out(0, 1, 1, 0, 0, 0); cycle("e2");
      ex_redirect = 1'b0;
      alu(5'd13, 5'd6, 5'd4); expect_out(0, 0, 0, 0, 0, 2); cycle("e3");
      for (int i = 0; i < 3; i++) begin
         nop(); expect_out(0, 0, 0, 0, 0, 0); cycle("e_nop");
      end

      // Memory wait with a writer in MEM; freeze also beats a redirect.
      alu(5'd14, 5'd1, 5'd2); expect_out(0, 0, 0, 0, 0, 0); cycle("f1");
      nop();                  expect_out(0, 0, 0, 0, 0, 0); cycle("f2");
      alu(5'd15, 5'd14, 5'd0);
      mem_busy = 1'b1;        expect_out(1, 0, 0, 1, 2, 0); cycle("f3");
      ex_redirect = 1'b1;     expect_out(1, 0, 0, 1, 2, 0); cycle("f4");
      ex_redirect = 1'b0;     expect_out(1, 0, 0, 1, 2, 0); cycle("f5");
      mem_busy = 1'b0;        expect_out(0, 0, 0, 0, 2, 0); cycle("f6");
      alu(5'd16, 5'd15, 5'd14); expect_out(0, 0, 0, 0, 1, 3); cycle("f7");
      for (int i = 0; i < 3; i++) begin
         nop(); expect_out(0, 0, 0, 0, 0, 0); cycle("f_nop");
      end

      // Reset in the middle of a load-use stall.
      lw(5'd4, 5'd1);         expect_out(0, 0, 0, 0, 0, 0); cycle("g1");
      alu(5'd6, 5'd4, 5'd4);  expect_out(1, 0, 1, 0, 0, 0); compare("g2");
      #2;
      reset  = 1'b0;
      exp_ps = 0;
      exp_pf = 0;
      #1;
      expect_out(0, 0, 0, 0, 0, 0); check_now("g_rst");
      @(posedge clk);
      #1;
      reset = 1'b1;
      expect_out(0, 0, 0, 0, 0, 0); cycle("g3");
      nop();                  expect_out(0, 0, 0, 0, 0, 0); cycle("g4");

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
